// File: rtl/hazard_ctrl.sv
// hazard_ctrl: holds the pipeline front end for the memory op in ID/EX, by fixed count or ack with timeout.
// Optional load-use filter enabled by defining HAZARD_DEPCHK_EN.
`ifndef HBIT_OPC
`define HBIT_OPC 4
`endif
`ifndef OPC_STui
`define OPC_STui 5'h10
`endif
`ifndef OPC_STsi
`define OPC_STsi 5'h11
`endif
`ifndef OPC_SRSTso
`define OPC_SRSTso 5'h12
`endif
`ifndef OPC_SRLDso
`define OPC_SRLDso 5'h13
`endif

module hazard_ctrl #(
  parameter int CNT_W       = 4,
  parameter int LOAD_STALL  = 3,
  parameter int STORE_STALL = 3,
  parameter int ACK_MODE    = 0,
  parameter int ACK_TIMEOUT = 7,
  parameter int RIDX_W      = 4
) (
  input  logic                iw_clk,
  input  logic                iw_rst,
  input  logic [`HBIT_OPC:0]  iw_idex_opc,
  input  logic                iw_idex_valid,
  input  logic [RIDX_W-1:0]   iw_idex_rd,
  input  logic [RIDX_W-1:0]   iw_ifid_rs1,
  input  logic [RIDX_W-1:0]   iw_ifid_rs2,
  input  logic                iw_ifid_rs1_re,
  input  logic                iw_ifid_rs2_re,
  input  logic                iw_mem_ack,
  output logic                ow_stall,
  output logic [1:0]          ow_busy_kind,
  output logic                ow_timeout
);
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  if (LOAD_STALL > CNT_MAX || STORE_STALL > CNT_MAX || ACK_TIMEOUT > CNT_MAX) begin : g_chk_w
    $error("hazard_ctrl: stall value exceeds counter range");
  end
  if (ACK_MODE != 0 && ACK_TIMEOUT < 1) begin : g_chk_to
    $error("hazard_ctrl: ACK_TIMEOUT must be >= 1");
  end
  localparam logic [CNT_W-1:0] LD_N = ACK_MODE != 0 ? CNT_W'(ACK_TIMEOUT) : CNT_W'(LOAD_STALL);
  localparam logic [CNT_W-1:0] ST_N = ACK_MODE != 0 ? CNT_W'(ACK_TIMEOUT) : CNT_W'(STORE_STALL);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [1:0]       r_kind, w_kind_nxt;
  logic             r_timeout, w_timeout_nxt;
  logic             w_is_ld, w_is_st, w_ld_dep, w_ld_go, w_st_go;
  assign w_is_ld = iw_idex_opc == `OPC_SRLDso;
  assign w_is_st = iw_idex_opc == `OPC_STui || iw_idex_opc == `OPC_STsi || iw_idex_opc == `OPC_SRSTso;
`ifdef HAZARD_DEPCHK_EN
  assign w_ld_dep = (iw_ifid_rs1_re && iw_ifid_rs1 == iw_idex_rd) ||
                    (iw_ifid_rs2_re && iw_ifid_rs2 == iw_idex_rd);
`else
  logic w_unused;
  assign w_unused = ^{iw_idex_rd, iw_ifid_rs1, iw_ifid_rs2, iw_ifid_rs1_re, iw_ifid_rs2_re};
  assign w_ld_dep = 1'b1;
`endif
  // A zero load/store count means that op class never stalls.
  assign w_ld_go = iw_idex_valid && w_is_ld && w_ld_dep && LD_N != '0;
  assign w_st_go = iw_idex_valid && w_is_st && ST_N != '0;
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_kind_nxt    = r_kind;
    w_timeout_nxt = 1'b0;
    if (r_state == IDLE) begin
      if (w_ld_go || w_st_go) begin
        w_state_nxt = BUSY;
        w_cnt_nxt   = w_ld_go ? LD_N : ST_N;
        w_kind_nxt  = w_ld_go ? 2'b01 : 2'b10;
      end
    end else if (ACK_MODE != 0 && iw_mem_ack) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end else if (r_cnt == CNT_W'(1)) begin
      w_state_nxt   = IDLE;
      w_cnt_nxt     = '0;
      w_timeout_nxt = ACK_MODE != 0;
    end else begin
      w_cnt_nxt = r_cnt - CNT_W'(1);
    end
  end
  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_kind    <= 2'b00;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_kind    <= w_kind_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end
  assign ow_stall     = r_state == BUSY;
  assign ow_busy_kind = r_state == BUSY ? r_kind : 2'b00;
  assign ow_timeout   = r_timeout;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of hazard_ctrl in fixed-count, split-count and ack modes.
`ifndef HBIT_OPC
`define HBIT_OPC 4
`endif
`ifndef OPC_STui
`define OPC_STui 5'h10
`endif
`ifndef OPC_STsi
`define OPC_STsi 5'h11
`endif
`ifndef OPC_SRSTso
`define OPC_SRSTso 5'h12
`endif
`ifndef OPC_SRLDso
`define OPC_SRLDso 5'h13
`endif

module tb_hazard_ctrl;
  logic               clk = 1'b0, rst = 1'b0;
  logic [`HBIT_OPC:0] opc;
  logic               valid, ack, re1, re2;
  logic [3:0]         rd, rs1, rs2;
  logic               s0, s1, s2, t0, t1, t2;
  logic [1:0]         k0, k1, k2;
  int                 n_pass = 0, n_tot = 0;
`ifdef HAZARD_DEPCHK_EN
  localparam bit DEP = 1'b1;
`else
  localparam bit DEP = 1'b0;
`endif
  localparam logic [`HBIT_OPC:0] NOP = '0;

  always #5 clk = ~clk;

  hazard_ctrl u0 (.iw_clk(clk), .iw_rst(rst), .iw_idex_opc(opc), .iw_idex_valid(valid),
    .iw_idex_rd(rd), .iw_ifid_rs1(rs1), .iw_ifid_rs2(rs2), .iw_ifid_rs1_re(re1),
    .iw_ifid_rs2_re(re2), .iw_mem_ack(ack), .ow_stall(s0), .ow_busy_kind(k0), .ow_timeout(t0));
  hazard_ctrl #(.LOAD_STALL(2), .STORE_STALL(5)) u1 (.iw_clk(clk), .iw_rst(rst),
    .iw_idex_opc(opc), .iw_idex_valid(valid), .iw_idex_rd(rd), .iw_ifid_rs1(rs1),
    .iw_ifid_rs2(rs2), .iw_ifid_rs1_re(re1), .iw_ifid_rs2_re(re2), .iw_mem_ack(ack),
    .ow_stall(s1), .ow_busy_kind(k1), .ow_timeout(t1));
  hazard_ctrl #(.ACK_MODE(1), .ACK_TIMEOUT(7)) u2 (.iw_clk(clk), .iw_rst(rst),
    .iw_idex_opc(opc), .iw_idex_valid(valid), .iw_idex_rd(rd), .iw_ifid_rs1(rs1),
    .iw_ifid_rs2(rs2), .iw_ifid_rs1_re(re1), .iw_ifid_rs2_re(re2), .iw_mem_ack(ack),
    .ow_stall(s2), .ow_busy_kind(k2), .ow_timeout(t2));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [`HBIT_OPC:0] o, input logic v);
    opc = o;
    valid = v;
  endtask

  task automatic do_reset;
    drive(NOP, 1'b0);
    ack = 1'b0; rd = 4'd5; rs1 = 4'd5; rs2 = 4'd6; re1 = 1'b1; re2 = 1'b1;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    tick;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #1;
    n_tot++;
    if ({s0, k0, t0, s1, k1, t1, s2, k2, t2} !== 12'b0)
      $display("FAIL reset outputs got %b want 0", {s0, k0, t0, s1, k1, t1, s2, k2, t2});
    else n_pass++;
    do_reset;
  endtask

  task automatic test_load_fixed;
    do_reset;
    drive(`OPC_SRLDso, 1'b1);
    tick;
    drive(NOP, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      n_tot++;
      if ({s0, k0} !== (i <= 3 ? 3'b101 : 3'b000))
        $display("FAIL load_fixed cyc T+%0d stall/kind got %b%b want %b", i, s0, k0,
                 (i <= 3 ? 3'b101 : 3'b000));
      else n_pass++;
      tick;
    end
  endtask

  task automatic test_back_to_back;
    logic [2:0] exp;
    do_reset;
    drive(`OPC_STsi, 1'b1);
    tick;
    drive(`OPC_SRLDso, 1'b1);
    for (int i = 1; i <= 9; i++) begin
      if (i == 7) drive(NOP, 1'b0);
      exp = i <= 5 ? 3'b110 : (i == 7 || i == 8) ? 3'b101 : 3'b000;
      n_tot++;
      if ({s1, k1} !== exp)
        $display("FAIL back_to_back cyc T+%0d stall/kind got %b%b want %b", i, s1, k1, exp);
      else n_pass++;
      tick;
    end
  endtask

  task automatic test_ack(input int ack_cyc, input string nm);
    logic [1:0] exp;
    do_reset;
    drive(`OPC_STui, 1'b1);
    tick;
    drive(NOP, 1'b0);
    for (int i = 1; i <= 9; i++) begin
      ack = i == ack_cyc;
      if (ack_cyc == 0) exp = {i <= 7, i == 8};
      else exp = {i <= ack_cyc, 1'b0};
      n_tot++;
      if ({s2, t2} !== exp)
        $display("FAIL %s cyc T+%0d stall/timeout got %b%b want %b", nm, i, s2, t2, exp);
      else n_pass++;
      tick;
    end
    ack = 1'b0;
  endtask

  task automatic test_valid0;
    do_reset;
    drive(`OPC_SRLDso, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      tick;
      n_tot++;
      if ({s0, s1, s2} !== 3'b000)
        $display("FAIL valid0 cyc %0d stalls got %b want 000", i, {s0, s1, s2});
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid;
    do_reset;
    drive(`OPC_SRLDso, 1'b1);
    tick;
    drive(NOP, 1'b0);
    tick;
    rst = 1'b1;
    #1;
    n_tot++;
    if ({s0, k0, t0, s2, k2} !== 7'b0)
      $display("FAIL reset_mid outputs got %b want 0", {s0, k0, t0, s2, k2});
    else n_pass++;
    tick;
    rst = 1'b0;
    drive(`OPC_SRLDso, 1'b1);
    tick;
    drive(NOP, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      n_tot++;
      if ({s0, k0} !== (i <= 3 ? 3'b101 : 3'b000))
        $display("FAIL reset_mid_reload cyc T+%0d got %b%b want %b", i, s0, k0,
                 (i <= 3 ? 3'b101 : 3'b000));
      else n_pass++;
      tick;
    end
  endtask

  task automatic test_depchk;
    logic want;
    do_reset;
    rd = 4'd5; rs1 = 4'd0; re1 = 1'b0; rs2 = 4'd5; re2 = 1'b1;
    drive(`OPC_SRLDso, 1'b1);
    tick;
    drive(NOP, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      n_tot++;
      if (s0 !== (i <= 3)) $display("FAIL dep_rs2 cyc T+%0d stall got %b want %b", i, s0, i <= 3);
      else n_pass++;
      tick;
    end
    rs1 = 4'd5; re1 = 1'b0; rs2 = 4'd6; re2 = 1'b1;
    drive(`OPC_SRLDso, 1'b1);
    tick;
    drive(NOP, 1'b0);
    want = !DEP;
    n_tot++;
    if (s0 !== want) $display("FAIL nodep_load stall got %b want %b", s0, want);
    else n_pass++;
    repeat (4) tick;
    drive(`OPC_SRSTso, 1'b1);
    tick;
    drive(NOP, 1'b0);
    n_tot++;
    if ({s0, k0} !== 3'b110) $display("FAIL nodep_store stall/kind got %b%b want 110", s0, k0);
    else n_pass++;
    repeat (4) tick;
  endtask

  initial begin
    drive(NOP, 1'b0);
    ack = 1'b0; rd = '0; rs1 = '0; rs2 = '0; re1 = 1'b0; re2 = 1'b0;
    test_reset;
    test_load_fixed;
    test_back_to_back;
    test_ack(3, "ack_early");
    test_ack(0, "ack_timeout");
    test_ack(7, "ack_at_last");
    test_valid0;
    test_reset_mid;
    test_depchk;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised memory-hazard controller for the amber pipeline, sitting between the ID/EX stage and the front-end stall network. It holds the front of the pipeline for the data-memory operation currently in ID/EX.
- Load and store stall lengths are configured independently.
- Stalls can end on a fixed count or on a memory acknowledge, with a timeout.
- An optional load-use dependency filter suppresses load stalls that no following instruction needs.
- Memory-result forwarding is out of scope.

## Interface
Parameters:
- CNT_W, 4: stall/timeout counter width. Elaboration fails if any stall value below exceeds 2^CNT_W-1.
- LOAD_STALL, 3: fixed stall cycles for loads (ACK_MODE=0). 0 means loads never stall.
- STORE_STALL, 3: fixed stall cycles for stores (ACK_MODE=0). 0 means stores never stall.
- ACK_MODE, 0: 0 = fixed count; 1 = acknowledge-terminated.
- ACK_TIMEOUT, 7: maximum stall cycles in ACK_MODE=1. Must be ≥1.
- RIDX_W, 4: register index width.

Ports:
- iw_clk  in  1  clock
- iw_rst  in  1  reset, asynchronous, active-high
- iw_idex_opc  in  `HBIT_OPC+1  opcode in ID/EX
- iw_idex_valid  in  1  ID/EX holds a real instruction (0 = bubble)
- iw_idex_rd  in  RIDX_W  destination register of the ID/EX instruction
- iw_ifid_rs1, iw_ifid_rs2  in  RIDX_W each  source registers of the IF/ID instruction
- iw_ifid_rs1_re, iw_ifid_rs2_re  in  1 each  IF/ID instruction reads rs1 / rs2
- iw_mem_ack  in  1  data memory completed the outstanding access
- ow_stall  out  1  hold PC and IF/ID; bubble into ID/EX
- ow_busy_kind  out  2  00 idle, 01 load stall, 10 store stall, 11 never driven
- ow_timeout  out  1  one-cycle pulse: ack-mode stall ended by timeout

## Operation
- Opcode classes:
  - Load = `OPC_SRLDso.
  - Store = `OPC_STui, `OPC_STsi, `OPC_SRSTso.
  - All other opcodes are non-memory.
- Two states: IDLE and BUSY. A down-counter r_cnt (CNT_W bits) and a kind register drive all outputs. All outputs are registered.
- Trigger: in IDLE, when iw_idex_valid=1 and the opcode is a memory op, the block loads r_cnt and the kind, then enters BUSY.
  - ACK_MODE=0: r_cnt loads LOAD_STALL or STORE_STALL. A value of 0 means no trigger; the block stays in IDLE.
  - ACK_MODE=1: r_cnt loads ACK_TIMEOUT.
- BUSY, ACK_MODE=0: r_cnt decrements every cycle. When r_cnt=1 the block returns to IDLE.
- BUSY, ACK_MODE=1:
  - If iw_mem_ack=1, the block returns to IDLE.
  - Otherwise, if r_cnt=1, the block returns to IDLE and pulses ow_timeout for the next cycle.
  - Otherwise r_cnt decrements.
  - Ack and the last count in the same cycle: ack wins, no timeout pulse.
- Trigger evaluation is masked in BUSY, and iw_mem_ack is ignored in IDLE.
- Outputs:
  - ow_stall = (state==BUSY).
  - ow_busy_kind = kind while BUSY, else 00.
- Reset (asynchronous) forces IDLE, r_cnt=0, ow_stall=0, ow_busy_kind=00, ow_timeout=0. Reset mid-stall aborts the stall immediately.

## Timing
- Trigger sampled in cycle T. ow_stall is high from cycle T+1.
- ACK_MODE=0: ow_stall is high for exactly N cycles (T+1..T+N) and low at T+N+1. A new trigger can be sampled at T+N+1.
- ACK_MODE=1: iw_mem_ack high in cycle A (A ≥ T+1) drops ow_stall at A+1.
- ACK_MODE=1 without an ack: ow_stall is high T+1..T+ACK_TIMEOUT. ow_timeout is high only in T+ACK_TIMEOUT+1.
- Back-to-back memory ops: the second one is sampled at the first IDLE cycle in which it is valid in ID/EX.

## Configuration
- HAZARD_DEPCHK_EN defined: a load triggers only when it depends on the IF/ID instruction, i.e. (iw_ifid_rs1_re && iw_ifid_rs1==iw_idex_rd) || (iw_ifid_rs2_re && iw_ifid_rs2==iw_idex_rd). No register index is special-cased. Stores always trigger.
- HAZARD_DEPCHK_EN undefined: every valid load triggers. The rd/rs/re inputs are unused.

## Test plan
- ACK_MODE=0, defaults: valid `OPC_SRLDso at T -> ow_stall high T+1..T+3, ow_busy_kind=01, idle at T+4.
- LOAD_STALL=2, STORE_STALL=5: `OPC_STsi at T, `OPC_SRLDso valid at T+6 -> stall T+1..T+5 (kind 10), then T+7..T+8 (kind 01). Any memory opcode presented during BUSY is ignored.
- ACK_MODE=1, ACK_TIMEOUT=7: store at T, ack at T+3 -> stall T+1..T+3, no timeout. Repeat with no ack -> stall T+1..T+7, ow_timeout only at T+8. Ack exactly at T+7 -> no timeout pulse.
- HAZARD_DEPCHK_EN: load rd=5 with IF/ID rs2=5, rs2_re=1 -> 3-cycle stall. Same load with rs1=5, rs1_re=0, rs2=6 -> no stall. Store always stalls.
- iw_idex_valid=0 with a load opcode -> no stall. Also: assert iw_rst at T+2 of a 3-cycle stall -> all outputs 0 immediately; release, then a load -> normal 3-cycle stall.
